// File: rtl/region_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// region_arbiter_pkg
//
// Shared definitions for the fifobram region write arbiter:
//   state_t   - arbiter FSM states (IDLE waiting for requests, BURST owned)
//   MEM_BIT   - wfifobram bit selecting the addressed memory target
//   FIFO_BIT  - wfifobram bit selecting the FIFO target
//   writes_region() - true when a beat targets at least one region side
// -----------------------------------------------------------------------------
package region_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int MEM_BIT  = 0;
    localparam int FIFO_BIT = 1;

    // A beat with neither target bit set is consumed but never written.
    function automatic logic writes_region(input logic [1:0] wfifobram);
        return wfifobram[MEM_BIT] | wfifobram[FIFO_BIT];
    endfunction

endpackage

// File: rtl/region_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Searches the request vector starting at
// the requester just after i_last_owner and wrapping at N-1 -> 0, so the
// previous owner is always considered last.
//
// Ports:
//   i_req        [N-1:0]     request vector
//   i_last_owner [IDXW-1:0]  index of the most recent owner
//   o_grant      [N-1:0]     one-hot winner (0 when no request)
//   o_idx        [IDXW-1:0]  index of the winner (0 when no request)
//   o_any                    at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_last_owner,
    output logic [N-1:0]    o_grant,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    int w_cand;

    // Walk the offsets from farthest to nearest; the last hit written is the
    // nearest requester after i_last_owner, which is the round-robin winner.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = N; k >= 1; k--) begin
            w_cand = int'(i_last_owner) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (i_req[w_cand[IDXW-1:0]]) begin
                o_grant                     = '0;
                o_grant[w_cand[IDXW-1:0]]   = 1'b1;
                o_idx                       = w_cand[IDXW-1:0];
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/region_write_arbiter.sv
// -----------------------------------------------------------------------------
// region_write_arbiter
//
// Shares the single write channel of a fifobram region between several
// requesters. Round-robin arbitration with burst locking: the owner keeps the
// channel until it offers a beat marked last or reaches MAX_BURST beats.
// FIFO-targeted beats stall while the region reports almostfull. The write
// channel is registered and drives the region write port directly.
//
// Ports:
//   clk              single clock, rising edge
//   reset            asynchronous reset, active low
//   req_valid  [N]   beat offered by requester i
//   req_last   [N]   offered beat ends requester i's burst
//   req_waddr  [N*LOG2_DEPTH]  packed per-requester address (MEM writes)
//   req_wdata  [N*WIDTH]       packed per-requester data
//   req_wfifobram [N*2]        packed per-requester target (bit0 MEM, bit1 FIFO)
//   req_ready  [N]   beat of requester i accepted this cycle
//   grant      [N]   one-hot current owner, 0 when idle
//   wr_almostfull    region FIFO almost full
//   wr_we / wr_waddr / wr_wdata / wr_wfifobram   region write channel
//   burst_truncated  one-cycle pulse when a burst is cut at MAX_BURST
// -----------------------------------------------------------------------------
module region_write_arbiter
    import region_arbiter_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int LOG2_DEPTH     = 5,
    parameter int NUM_REQUESTERS = 4,
    parameter int MAX_BURST      = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS-1:0]            req_last,
    input  logic [NUM_REQUESTERS*LOG2_DEPTH-1:0] req_waddr,
    input  logic [NUM_REQUESTERS*WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQUESTERS*2-1:0]          req_wfifobram,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic [NUM_REQUESTERS-1:0]            grant,
    input  logic                                 wr_almostfull,
    output logic                                 wr_we,
    output logic [LOG2_DEPTH-1:0]                wr_waddr,
    output logic [WIDTH-1:0]                     wr_wdata,
    output logic [1:0]                           wr_wfifobram,
    output logic                                 burst_truncated
);

    localparam int IDXW = $clog2(NUM_REQUESTERS);
    // One extra bit so the counter can represent MAX_BURST itself.
    localparam int CNTW = $clog2(MAX_BURST) + 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                      r_state;
    logic [NUM_REQUESTERS-1:0]   r_grant;
    logic [IDXW-1:0]             r_owner;
    logic [IDXW-1:0]             r_last_owner;
    logic [CNTW-1:0]             r_count;
    logic                        r_we;
    logic [LOG2_DEPTH-1:0]       r_waddr;
    logic [WIDTH-1:0]            r_wdata;
    logic [1:0]                  r_wfifobram;
    logic                        r_trunc;

    // ------------------------------------------------------------------
    // Per-requester views of the packed buses
    // ------------------------------------------------------------------
    logic [LOG2_DEPTH-1:0] w_waddr_arr [NUM_REQUESTERS];
    logic [WIDTH-1:0]      w_wdata_arr [NUM_REQUESTERS];
    logic [1:0]            w_wf_arr    [NUM_REQUESTERS];

    // Owner-selected beat and handshake
    logic                  w_own_valid;
    logic                  w_own_last;
    logic [1:0]            w_own_wf;
    logic                  w_stall;
    logic                  w_accept;
    logic [CNTW-1:0]       w_count_inc;
    logic                  w_hit_max;
    logic                  w_release;

    // Picker outputs
    logic [NUM_REQUESTERS-1:0] w_pick_grant;
    logic [IDXW-1:0]           w_pick_idx;
    logic                      w_pick_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_req
            assign w_waddr_arr[gi] = req_waddr[gi*LOG2_DEPTH +: LOG2_DEPTH];
            assign w_wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
            assign w_wf_arr[gi]    = req_wfifobram[gi*2 +: 2];
            // Only the owner ever sees ready; everyone else holds its beat.
            assign req_ready[gi]   = w_accept && (r_owner == IDXW'(gi));
        end
    endgenerate

    rr_pick #(
        .N    (NUM_REQUESTERS),
        .IDXW (IDXW)
    ) u_rr_pick (
        .i_req        (req_valid),
        .i_last_owner (r_last_owner),
        .o_grant      (w_pick_grant),
        .o_idx        (w_pick_idx),
        .o_any        (w_pick_any)
    );

    assign w_own_valid = req_valid[r_owner];
    assign w_own_last  = req_last[r_owner];
    assign w_own_wf    = w_wf_arr[r_owner];

    // almostfull is used combinationally; its threshold leaves room for the
    // one beat already sitting in the output register.
    assign w_stall     = w_own_wf[FIFO_BIT] && wr_almostfull;
    assign w_accept    = (r_state == BURST) && w_own_valid && !w_stall;

    assign w_count_inc = r_count + 1'b1;
    assign w_hit_max   = (w_count_inc == CNTW'(MAX_BURST));
    assign w_release   = w_accept && (w_own_last || w_hit_max);

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            // Last owner starts at the top index so requester 0 wins first.
            r_last_owner <= IDXW'(NUM_REQUESTERS - 1);
            r_count      <= '0;
            r_trunc      <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Grant takes effect next cycle; no beat is taken here,
                    // which gives the one idle cycle between bursts.
                    if (w_pick_any) begin
                        r_state <= BURST;
                        r_grant <= w_pick_grant;
                        r_owner <= w_pick_idx;
                        r_count <= '0;
                    end
                end
                BURST: begin
                    // An owner that drops valid simply keeps the grant.
                    if (w_accept) begin
                        r_count <= w_count_inc;
                    end
                    if (w_release) begin
                        r_state      <= IDLE;
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        // Release without last can only be the length cap.
                        r_trunc      <= !w_own_last;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered write channel. Address/data/target only move on a real
    // write, so they hold their previous values while wr_we is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_wfifobram <= 2'b00;
        end else begin
            r_we <= 1'b0;
            if (w_accept && writes_region(w_own_wf)) begin
                r_we        <= 1'b1;
                r_waddr     <= w_waddr_arr[r_owner];
                r_wdata     <= w_wdata_arr[r_owner];
                r_wfifobram <= w_own_wf;
            end
        end
    end

    assign grant           = r_grant;
    assign wr_we           = r_we;
    assign wr_waddr        = r_waddr;
    assign wr_wdata        = r_wdata;
    assign wr_wfifobram    = r_wfifobram;
    assign burst_truncated = r_trunc;

endmodule

// File: tb/tb_region_write_arbiter.sv
module tb_region_write_arbiter;

    localparam int N  = 4;
    localparam int LW = 5;
    localparam int W  = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*LW-1:0] req_waddr = '0;
    logic [N*W-1:0]  req_wdata = '0;
    logic [N*2-1:0]  req_wfifobram = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic            wr_almostfull = 1'b0;
    logic            wr_we;
    logic [LW-1:0]   wr_waddr;
    logic [W-1:0]    wr_wdata;
    logic [1:0]      wr_wfifobram;
    logic            burst_truncated;

    always #5 clk = ~clk;

    region_write_arbiter #(
        .WIDTH(W), .LOG2_DEPTH(LW), .NUM_REQUESTERS(N), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_waddr(req_waddr),
        .req_wdata(req_wdata), .req_wfifobram(req_wfifobram),
        .req_ready(req_ready), .grant(grant), .wr_almostfull(wr_almostfull),
        .wr_we(wr_we), .wr_waddr(wr_waddr), .wr_wdata(wr_wdata),
        .wr_wfifobram(wr_wfifobram), .burst_truncated(burst_truncated)
    );

    typedef struct packed {
        logic [LW-1:0] a;
        logic [W-1:0]  d;
        logic [1:0]    f;
        logic          l;
    } beat_t;

    beat_t q [N][$];

    // Reference model: who owns the channel, how many beats it has had,
    // and what the write channel should show in the coming cycle.
    int            m_owner;
    int            m_last_owner;
    int            m_beats;
    logic          m_we;
    logic          m_trunc;
    logic [LW-1:0] m_waddr;
    logic [W-1:0]  m_wdata;
    logic [1:0]    m_wf;
    logic [N-1:0]  exp_ready;

    int   n_checks = 0;
    int   n_err    = 0;
    int   we_seen  = 0;
    int   trunc_seen = 0;
    logic [N-1:0] last_ready;
    bit   gaps = 1'b0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input int a, input int d, input int f, input int l);
        beat_t b;
        b.a = LW'(a);
        b.d = W'(d);
        b.f = 2'(f);
        b.l = 1'(l);
        return b;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last_owner = N - 1;
        m_beats = 0;
        m_we = 1'b0;
        m_trunc = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_wf = 2'b00;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = q[i][0].l;
                req_waddr[i*LW +: LW] = q[i][0].a;
                req_wdata[i*W +: W]   = q[i][0].d;
                req_wfifobram[i*2 +: 2] = q[i][0].f;
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'($urandom_range(1));
                req_waddr[i*LW +: LW] = LW'($urandom);
                req_wdata[i*W +: W]   = W'($urandom);
                req_wfifobram[i*2 +: 2] = 2'($urandom_range(3));
            end
        end
    endtask

    // One clock: drive, check mid-cycle, advance the model on the edge.
    task automatic cycle();
        logic       nwe;
        logic       ntr;
        logic [1:0] f;
        int         o;
        drive();
        @(negedge clk);
        exp_ready = '0;
        if (m_owner >= 0) begin
            o = m_owner;
            if (req_valid[o] && !(req_wfifobram[2*o+1] && wr_almostfull))
                exp_ready[o] = 1'b1;
        end
        chk("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("wr_we", 32'(wr_we), 32'(m_we));
        chk("wr_waddr", 32'(wr_waddr), 32'(m_waddr));
        chk("wr_wdata", 32'(wr_wdata), 32'(m_wdata));
        chk("wr_wfifobram", 32'(wr_wfifobram), 32'(m_wf));
        chk("burst_truncated", 32'(burst_truncated), 32'(m_trunc));
        last_ready = req_ready;
        if (wr_we === 1'b1) we_seen++;
        if (burst_truncated === 1'b1) trunc_seen++;
        @(posedge clk);
        nwe = 1'b0;
        ntr = 1'b0;
        if (m_owner < 0) begin
            if (|req_valid) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_last_owner + k) % N]) begin
                        m_owner = (m_last_owner + k) % N;
                        break;
                    end
                end
                m_beats = 0;
            end
        end else if (exp_ready[m_owner]) begin
            o = m_owner;
            m_beats++;
            f = req_wfifobram[2*o +: 2];
            if (f != 2'b00) begin
                nwe = 1'b1;
                m_waddr = req_waddr[o*LW +: LW];
                m_wdata = req_wdata[o*W +: W];
                m_wf = f;
            end
            if (req_last[o] || m_beats == MB) begin
                ntr = !req_last[o];
                m_last_owner = o;
                m_owner = -1;
            end
        end
        m_we = nwe;
        m_trunc = ntr;
        for (int i = 0; i < N; i++)
            if (exp_ready[i]) void'(q[i].pop_front());
        #1;
    endtask

    task automatic run_until_empty(input int max_cycles);
        int c;
        int rem;
        c = 0;
        rem = 0;
        for (int i = 0; i < N; i++) rem += q[i].size();
        while (rem > 0 && c < max_cycles) begin
            cycle();
            c++;
            rem = 0;
            for (int i = 0; i < N; i++) rem += q[i].size();
        end
        chk("drain_bound", 32'(rem), 32'd0);
        for (int i = 0; i < N; i++) q[i].delete();
        cycle();
        cycle();
    endtask

    int we0;
    int tr0;
    int nb;

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we", 32'(wr_we), 32'd0);
        chk("rst_waddr", 32'(wr_waddr), 32'd0);
        chk("rst_trunc", 32'(burst_truncated), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Requesters 0 and 2 together: 0 first, one idle cycle, then 2.
        q[0].push_back(mk(1, 8'h11, 1, 1));
        q[2].push_back(mk(2, 8'h22, 1, 1));
        cycle();
        chk("a_grant_first", 32'(grant), 32'h1);
        cycle();
        chk("a_grant_released", 32'(grant), 32'h0);
        cycle();
        chk("a_grant_second", 32'(grant), 32'h4);
        run_until_empty(20);

        // Three MEM beats from requester 1.
        we0 = we_seen;
        q[1].push_back(mk(5, 8'hA1, 1, 0));
        q[1].push_back(mk(6, 8'hA2, 1, 0));
        q[1].push_back(mk(7, 8'hA3, 1, 1));
        run_until_empty(20);
        chk("b_we_count", 32'(we_seen - we0), 32'd3);

        // FIFO beat held off by almostfull for four cycles.
        we0 = we_seen;
        wr_almostfull = 1'b1;
        q[0].push_back(mk(9, 8'h5C, 2, 1));
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("c_stall_ready", 32'(last_ready), 32'd0);
        end
        wr_almostfull = 1'b0;
        cycle();
        chk("c_accept_ready", 32'(last_ready), 32'h1);
        cycle();
        cycle();
        cycle();
        chk("c_we_count", 32'(we_seen - we0), 32'd1);

        // Requester 3 streams 20 beats, last only on the final one.
        we0 = we_seen;
        tr0 = trunc_seen;
        for (int i = 1; i <= 20; i++)
            q[3].push_back(mk(i, 8'h30 + i, $urandom_range(3, 1), (i == 20) ? 1 : 0));
        run_until_empty(60);
        chk("d_trunc_count", 32'(trunc_seen - tr0), 32'd1);
        chk("d_we_count", 32'(we_seen - we0), 32'd20);

        // Dropped 2'b00 beats still count toward MAX_BURST; 2'b11 writes both.
        we0 = we_seen;
        tr0 = trunc_seen;
        for (int i = 0; i < 15; i++) q[1].push_back(mk(i, 8'hE0 + i, 0, 0));
        q[1].push_back(mk(20, 8'hEF, 3, 0));
        q[1].push_back(mk(21, 8'hF0, 3, 1));
        run_until_empty(60);
        chk("e_trunc_count", 32'(trunc_seen - tr0), 32'd1);
        chk("e_we_count", 32'(we_seen - we0), 32'd2);
        chk("e_wf_hold", 32'(wr_wfifobram), 32'd3);

        // Reset while a beat is in flight.
        for (int i = 0; i < 5; i++) q[2].push_back(mk(i, 8'h90 + i, 1, (i == 4) ? 1 : 0));
        cycle();
        cycle();
        chk("f_we_before", 32'(wr_we), 32'd1);
        reset = 1'b0;
        req_valid = '0;
        #1;
        chk("f_we_async", 32'(wr_we), 32'd0);
        chk("f_grant_async", 32'(grant), 32'd0);
        chk("f_wdata_async", 32'(wr_wdata), 32'd0);
        model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        q[3].push_back(mk(3, 8'h33, 1, 1));
        q[0].push_back(mk(4, 8'h44, 1, 1));
        cycle();
        chk("f_grant_after_reset", 32'(grant), 32'h1);
        run_until_empty(20);

        // Randomised traffic with gaps and almostfull toggling.
        gaps = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(7) == 0) begin
                    nb = $urandom_range(24, 1);
                    for (int b = 0; b < nb; b++)
                        q[i].push_back(mk($urandom, $urandom, $urandom_range(3),
                                          (b == nb - 1 || $urandom_range(5) == 0) ? 1 : 0));
                end
            end
            wr_almostfull = ($urandom_range(3) == 0);
            cycle();
        end
        gaps = 1'b0;
        wr_almostfull = 1'b0;
        run_until_empty(1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
